// File: rtl/dmem_arbiter_if.sv
// Signal bundle around dmem_arbiter: CPU port, host port and memory side.
// slave is the arbiter's view; master is the requesters plus the memory.
interface dmem_arbiter_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              cpu_req;
    logic              cpu_we;
    logic [31:0]       cpu_addr;
    logic [DATA_W-1:0] cpu_wdata;
    logic              cpu_ack;
    logic [DATA_W-1:0] cpu_rdata;
    logic              cpu_stall;

    logic              host_req;
    logic              host_we;
    logic [ADDR_W-1:0] host_addr;
    logic [DATA_W-1:0] host_wdata;
    logic              host_lock;
    logic              host_ack;
    logic [DATA_W-1:0] host_rdata;

    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  host_req, host_we, host_addr, host_wdata, host_lock,
        input  mem_rdata,
        output cpu_ack, cpu_rdata, cpu_stall,
        output host_ack, host_rdata,
        output mem_en, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output host_req, host_we, host_addr, host_wdata, host_lock,
        output mem_rdata,
        input  cpu_ack, cpu_rdata, cpu_stall,
        input  host_ack, host_rdata,
        input  mem_en, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter sharing one synchronous-read data memory between CPU and host.
// Define DMEM_ARB_LOCK_EN to let the host hold exclusive access via host_lock.
module dmem_arbiter #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
) (
    input  logic          clk,
    input  logic          rst,
    dmem_arbiter_if.slave bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_ACC  = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_CPU  = 1'b0;
    localparam logic PORT_HOST = 1'b1;

    logic [1:0]        state_q, state_d;
    logic              prio_q, prio_d;
    logic              grant_q, grant_d;
    logic              mem_en_q, mem_en_d;
    logic              mem_we_q, mem_we_d;
    logic              op_we_q, op_we_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DATA_W-1:0] host_rdata_q, host_rdata_d;
    logic              cpu_ok;
    logic              start;
    logic              unused_bits;

`ifdef DMEM_ARB_LOCK_EN
    logic              locked_q, locked_d;

    // A locked host hides the CPU from arbitration, which also freezes prio.
    assign cpu_ok = bus.cpu_req & ~locked_q;
`else
    assign cpu_ok = bus.cpu_req;
`endif

    assign start       = cpu_ok | bus.host_req;
    assign unused_bits = ^{bus.cpu_addr[31:ADDR_W], bus.host_lock};

    always_comb begin
        state_d      = state_q;
        prio_d       = prio_q;
        grant_d      = grant_q;
        mem_en_d     = mem_en_q;
        mem_we_d     = mem_we_q;
        op_we_d      = op_we_q;
        mem_addr_d   = mem_addr_q;
        mem_wdata_d  = mem_wdata_q;
        cpu_rdata_d  = cpu_rdata_q;
        host_rdata_d = host_rdata_q;
`ifdef DMEM_ARB_LOCK_EN
        locked_d     = locked_q;
`endif
        case (state_q)
            ST_IDLE: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                if (start) begin
                    if (cpu_ok && bus.host_req) begin
                        grant_d = prio_q;
                        prio_d  = ~prio_q;
                    end else begin
                        grant_d = cpu_ok ? PORT_CPU : PORT_HOST;
                    end
                    state_d  = ST_ACC;
                    mem_en_d = 1'b1;
                    if (grant_d == PORT_CPU) begin
                        mem_we_d    = bus.cpu_we;
                        mem_addr_d  = bus.cpu_addr[ADDR_W-1:0];
                        mem_wdata_d = bus.cpu_wdata;
                    end else begin
                        mem_we_d    = bus.host_we;
                        mem_addr_d  = bus.host_addr;
                        mem_wdata_d = bus.host_wdata;
                    end
                    op_we_d = mem_we_d;
                end
`ifdef DMEM_ARB_LOCK_EN
                if (!bus.host_lock) begin
                    locked_d = 1'b0;
                end else if (start && grant_d == PORT_HOST) begin
                    locked_d = 1'b1;
                end
`endif
            end
            ST_ACC: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (!op_we_q) begin
                    if (grant_q == PORT_CPU) begin
                        cpu_rdata_d = bus.mem_rdata;
                    end else begin
                        host_rdata_d = bus.mem_rdata;
                    end
                end
                state_d = ST_IDLE;
            end
            default: begin
                mem_en_d = 1'b0;
                mem_we_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            prio_q       <= PORT_CPU;
            grant_q      <= PORT_CPU;
            mem_en_q     <= 1'b0;
            mem_we_q     <= 1'b0;
            op_we_q      <= 1'b0;
            mem_addr_q   <= '0;
            mem_wdata_q  <= '0;
            cpu_rdata_q  <= '0;
            host_rdata_q <= '0;
`ifdef DMEM_ARB_LOCK_EN
            locked_q     <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            prio_q       <= prio_d;
            grant_q      <= grant_d;
            mem_en_q     <= mem_en_d;
            mem_we_q     <= mem_we_d;
            op_we_q      <= op_we_d;
            mem_addr_q   <= mem_addr_d;
            mem_wdata_q  <= mem_wdata_d;
            cpu_rdata_q  <= cpu_rdata_d;
            host_rdata_q <= host_rdata_d;
`ifdef DMEM_ARB_LOCK_EN
            locked_q     <= locked_d;
`endif
        end
    end

    // Read data is forwarded straight from memory during the ack cycle, then held.
    assign bus.cpu_ack    = (state_q == ST_RESP) && (grant_q == PORT_CPU);
    assign bus.host_ack   = (state_q == ST_RESP) && (grant_q == PORT_HOST);
    assign bus.cpu_rdata  = (bus.cpu_ack && !op_we_q) ? bus.mem_rdata : cpu_rdata_q;
    assign bus.host_rdata = (bus.host_ack && !op_we_q) ? bus.mem_rdata : host_rdata_q;
    assign bus.cpu_stall  = bus.cpu_req & ~bus.cpu_ack;

    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: vector table, corner-case sequences,
// and randomized traffic scored against a shadow memory.
module tb_dmem_arbiter;

    localparam int ADDR_W = 10;
    localparam int DATA_W = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic mem_load = 1'b1;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    dmem_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    dmem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Synchronous-read memory; preload puts i+4 in every word.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (mem_load) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 32'(i + 4);
            bus.mem_rdata <= '0;
        end else if (bus.mem_en) begin
            if (bus.mem_we) mem[bus.mem_addr] <= bus.mem_wdata;
            bus.mem_rdata <= mem[bus.mem_addr];
        end
    end

    typedef struct {
        logic        is_host;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [9:0]  exp_addr;
        logic [31:0] exp_cpu_rdata;
        logic [31:0] exp_host_rdata;
    } vec_t;

    vec_t        vecs [8];
    logic [31:0] shadow [0:1023];
    logic [31:0] last_cpu_rd;
    logic [31:0] last_host_rd;

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idleInputs();
        bus.cpu_req    = 1'b0;
        bus.cpu_we     = 1'b0;
        bus.cpu_addr   = '0;
        bus.cpu_wdata  = '0;
        bus.host_req   = 1'b0;
        bus.host_we    = 1'b0;
        bus.host_addr  = '0;
        bus.host_wdata = '0;
        bus.host_lock  = 1'b0;
    endtask

    task automatic doReset();
        @(posedge clk); #1;
        idleInputs();
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    task automatic applyStimulus(input vec_t v);
        @(posedge clk); #1;
        if (v.is_host) begin
            bus.host_req   = 1'b1;
            bus.host_we    = v.we;
            bus.host_addr  = v.addr[9:0];
            bus.host_wdata = v.wdata;
        end else begin
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = v.we;
            bus.cpu_addr  = v.addr;
            bus.cpu_wdata = v.wdata;
        end
    endtask

    // Single transaction from idle: strobe at N+1, ack at N+2.
    task automatic runVector(input vec_t v);
        applyStimulus(v);
        @(negedge clk);
        checkOutput("vec N mem_en", bus.mem_en, 1'b0);
        if (!v.is_host) checkOutput("vec N cpu_stall", bus.cpu_stall, 1'b1);
        @(negedge clk);
        checkOutput("vec N+1 mem_en", bus.mem_en, 1'b1);
        checkOutput("vec N+1 mem_we", bus.mem_we, v.we);
        checkOutput("vec N+1 mem_addr", bus.mem_addr, v.exp_addr);
        if (v.we) checkOutput("vec N+1 mem_wdata", bus.mem_wdata, v.wdata);
        checkOutput("vec N+1 acks", {bus.cpu_ack, bus.host_ack}, 2'b00);
        if (!v.is_host) checkOutput("vec N+1 cpu_stall", bus.cpu_stall, 1'b1);
        @(negedge clk);
        checkOutput("vec N+2 acks", {bus.cpu_ack, bus.host_ack}, v.is_host ? 2'b01 : 2'b10);
        checkOutput("vec N+2 mem_en", bus.mem_en, 1'b0);
        checkOutput("vec N+2 cpu_rdata", bus.cpu_rdata, v.exp_cpu_rdata);
        checkOutput("vec N+2 host_rdata", bus.host_rdata, v.exp_host_rdata);
        checkOutput("vec N+2 cpu_stall", bus.cpu_stall, 1'b0);
        @(posedge clk); #1;
        idleInputs();
        @(negedge clk);
        checkOutput("vec after acks", {bus.cpu_ack, bus.host_ack}, 2'b00);
    endtask

    task automatic cpuWorker(input int count);
        logic [31:0] a;
        logic [31:0] d;
        logic        we;
        logic        got;
        int          gap;
        for (int t = 0; t < count; t++) begin
            gap = $urandom_range(0, 3);
            bus.cpu_req = 1'b0;
            for (int g = 0; g < gap; g++) begin
                @(negedge clk);
                checkOutput("rand cpu_stall idle", bus.cpu_stall, 1'b0);
                @(posedge clk); #1;
            end
            a = $urandom;
            a[9:4] = '0;
            d = $urandom;
            we = 1'($urandom_range(0, 1));
            bus.cpu_req   = 1'b1;
            bus.cpu_we    = we;
            bus.cpu_addr  = a;
            bus.cpu_wdata = d;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (bus.cpu_ack) got = 1'b1;
                else checkOutput("rand cpu_stall wait", bus.cpu_stall, 1'b1);
            end
            checkOutput("rand cpu ack in time", got, 1'b1);
            if (got) begin
                checkOutput("rand dual ack", bus.host_ack, 1'b0);
                checkOutput("rand cpu_stall at ack", bus.cpu_stall, 1'b0);
                if (we) begin
                    checkOutput("rand cpu rdata held", bus.cpu_rdata, last_cpu_rd);
                    shadow[a[9:0]] = d;
                end else begin
                    checkOutput("rand cpu rdata", bus.cpu_rdata, shadow[a[9:0]]);
                    last_cpu_rd = shadow[a[9:0]];
                end
            end
            @(posedge clk); #1;
            bus.cpu_req = 1'b0;
        end
    endtask

    task automatic hostWorker(input int count);
        logic [9:0]  a;
        logic [31:0] d;
        logic        we;
        logic        got;
        int          gap;
        for (int t = 0; t < count; t++) begin
            gap = $urandom_range(0, 3);
            bus.host_req = 1'b0;
            repeat (gap) @(posedge clk);
            #1;
            a = 10'($urandom_range(0, 15));
            d = $urandom;
            we = 1'($urandom_range(0, 1));
            bus.host_req   = 1'b1;
            bus.host_we    = we;
            bus.host_addr  = a;
            bus.host_wdata = d;
            got = 1'b0;
            for (int c = 0; c < 20 && !got; c++) begin
                @(negedge clk);
                if (bus.host_ack) got = 1'b1;
            end
            checkOutput("rand host ack in time", got, 1'b1);
            if (got) begin
                if (we) begin
                    checkOutput("rand host rdata held", bus.host_rdata, last_host_rd);
                    shadow[a] = d;
                end else begin
                    checkOutput("rand host rdata", bus.host_rdata, shadow[a]);
                    last_host_rd = shadow[a];
                end
            end
            @(posedge clk); #1;
            bus.host_req = 1'b0;
        end
    endtask

    initial begin
        logic [5:0]  cpu_hist;
        logic [5:0]  host_hist;
        logic [31:0] host_rd;
        logic [3:0]  order;
        logic        seen;
        int          n;
        int          hcount;
        vec_t        v;

        vecs[0] = '{1'b0, 1'b0, 32'd5,          32'h0,  10'd5,    32'd9,   32'd0};
        vecs[1] = '{1'b0, 1'b1, 32'd1025,       32'hAB, 10'd1,    32'd9,   32'd0};
        vecs[2] = '{1'b0, 1'b0, 32'd1,          32'h0,  10'd1,    32'hAB,  32'd0};
        vecs[3] = '{1'b1, 1'b0, 32'd5,          32'h0,  10'd5,    32'hAB,  32'd9};
        vecs[4] = '{1'b1, 1'b1, 32'd3,          32'h77, 10'd3,    32'hAB,  32'd9};
        vecs[5] = '{1'b0, 1'b0, 32'hFFFF_FC03,  32'h0,  10'd3,    32'h77,  32'd9};
        vecs[6] = '{1'b1, 1'b0, 32'd1023,       32'h0,  10'd1023, 32'h77,  32'd1027};
        vecs[7] = '{1'b0, 1'b0, 32'd0,          32'h0,  10'd0,    32'd4,   32'd1027};

        idleInputs();
        @(negedge clk);
        checkOutput("reset mem_en", bus.mem_en, 1'b0);
        checkOutput("reset mem_we", bus.mem_we, 1'b0);
        checkOutput("reset mem_addr", bus.mem_addr, 10'd0);
        checkOutput("reset mem_wdata", bus.mem_wdata, 32'd0);
        checkOutput("reset acks", {bus.cpu_ack, bus.host_ack}, 2'b00);
        checkOutput("reset cpu_rdata", bus.cpu_rdata, 32'd0);
        checkOutput("reset host_rdata", bus.host_rdata, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        mem_load = 1'b0;
        @(negedge clk);
        checkOutput("idle mem_en", bus.mem_en, 1'b0);

        for (int i = 0; i < 8; i++) runVector(vecs[i]);

        // Both request together: CPU first, host re-arbitrated afterwards.
        doReset();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_we = 1'b1; bus.cpu_addr = 32'd3; bus.cpu_wdata = 32'd7;
        bus.host_req = 1'b1; bus.host_we = 1'b0; bus.host_addr = 10'd3;
        cpu_hist = '0; host_hist = '0; host_rd = '0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            cpu_hist[c]  = bus.cpu_ack;
            host_hist[c] = bus.host_ack;
            if (bus.host_ack) host_rd = bus.host_rdata;
            if (bus.cpu_ack || bus.host_ack) begin
                seen = bus.cpu_ack;
                @(posedge clk); #1;
                if (seen) bus.cpu_req = 1'b0;
                else bus.host_req = 1'b0;
            end
        end
        checkOutput("both cpu ack cycle", cpu_hist, 6'b000100);
        checkOutput("both host ack cycle", host_hist, 6'b100000);
        checkOutput("both host rdata", host_rd, 32'd7);
        idleInputs();

        // Both held requesting: strict alternation.
        doReset();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'd10;
        bus.host_req = 1'b1; bus.host_addr = 10'd11;
        n = 0; order = '0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.host_ack) begin
                order[n] = bus.host_ack;
                n++;
            end
            if (n == 4) begin
                @(posedge clk); #1;
                idleInputs();
            end
        end
        checkOutput("rr grant count", n, 4);
        checkOutput("rr grant order", order, 4'b1010);
        idleInputs();

        // Reset during the ACC cycle drops the access.
        doReset();
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'd5;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst-acc mem_en before", bus.mem_en, 1'b1);
        #1 rst = 1'b1;
        #1;
        checkOutput("rst-acc mem_en", bus.mem_en, 1'b0);
        checkOutput("rst-acc mem_addr", bus.mem_addr, 10'd0);
        checkOutput("rst-acc acks", {bus.cpu_ack, bus.host_ack}, 2'b00);
        @(posedge clk); #1;
        rst = 1'b0;
        idleInputs();
        seen = 1'b0;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            seen = seen | bus.cpu_ack | bus.host_ack | bus.mem_en;
        end
        checkOutput("rst-acc no activity", seen, 1'b0);
        v = '{1'b0, 1'b0, 32'd7, 32'h0, 10'd7, 32'd11, 32'd0};
        runVector(v);

        // Host lock: exclusive when enabled, alternation otherwise.
        doReset();
        @(posedge clk); #1;
        bus.host_req = 1'b1; bus.host_lock = 1'b1; bus.host_addr = 10'd20;
        @(posedge clk); #1;
        bus.cpu_req = 1'b1; bus.cpu_addr = 32'd21;
        n = 0; hcount = 0; order = '0;
        for (int c = 0; c < 60 && n < 4; c++) begin
            @(negedge clk);
            if (bus.cpu_ack || bus.host_ack) begin
                order[n] = bus.host_ack;
                n++;
                if (bus.host_ack) hcount++;
                if (n == 4 || (bus.host_ack && hcount == 3)) begin
                    @(posedge clk); #1;
                    bus.host_req = 1'b0;
                    bus.host_lock = 1'b0;
                    if (n == 4) bus.cpu_req = 1'b0;
                end
            end
        end
        checkOutput("lock grant count", n, 4);
`ifdef DMEM_ARB_LOCK_EN
        checkOutput("lock grant order", order, 4'b0111);
`else
        checkOutput("lock grant order", order, 4'b0101);
`endif
        idleInputs();

        // Randomized traffic against a shadow memory.
        @(posedge clk); #1;
        mem_load = 1'b1;
        @(posedge clk); #1;
        mem_load = 1'b0;
        for (int i = 0; i < 1024; i++) shadow[i] = 32'(i + 4);
        doReset();
        last_cpu_rd = '0;
        last_host_rd = '0;
        fork
            cpuWorker(40);
            hostWorker(40);
        join
        idleInputs();
        repeat (3) @(posedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
